// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational RV32I ALU between two requesters.
// Legal op: handshake N -> ALU operands N+1 -> response N+2; responses held until consumed.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result0,
  output logic [WIDTH-1:0]  rsp_result1,
  output logic [1:0]        rsp_zero,
  output logic [1:0]        rsp_err,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(6);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t             r_state;
  logic               r_last_grant;
  logic               r_owner;
  logic               r_busy;
  logic [1:0]         r_rsp_valid;
  logic [1:0]         r_rsp_zero;
  logic [1:0]         r_rsp_err;
  logic [WIDTH-1:0]   r_rsp_result0;
  logic [WIDTH-1:0]   r_rsp_result1;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [CTRL_W-1:0]  r_alu_ctrl;

  logic [1:0]         w_elig;
  logic [1:0]         w_gnt;
  logic               w_idx;
  logic               w_hs;
  logic               w_legal;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [CTRL_W-1:0]  w_ctrl;

  // A requester with an unconsumed response is held off so its slot can never be overwritten.
  always_comb begin
    w_elig = req_valid & ~r_rsp_valid;
    if (w_elig == 2'b11) w_gnt = r_last_grant ? 2'b01 : 2'b10;
    else                 w_gnt = w_elig;
    w_idx   = w_gnt[1];
    w_a     = w_idx ? req_a1    : req_a0;
    w_b     = w_idx ? req_b1    : req_b0;
    w_ctrl  = w_idx ? req_ctrl1 : req_ctrl0;
    w_legal = (w_ctrl == OP_AND) || (w_ctrl == OP_OR) ||
              (w_ctrl == OP_ADD) || (w_ctrl == OP_SUB);
  end

  assign req_ready = (r_state == S_IDLE && rst_n) ? w_gnt : 2'b00;
  assign w_hs      = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 2'b00;
      r_rsp_zero    <= 2'b00;
      r_rsp_err     <= 2'b00;
      r_rsp_result0 <= '0;
      r_rsp_result1 <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctrl    <= OP_ADD;
    end else begin
      r_rsp_valid <= r_rsp_valid & ~rsp_ready;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_last_grant <= w_idx;
            if (w_legal) begin
              r_alu_a    <= w_a;
              r_alu_b    <= w_b;
              r_alu_ctrl <= w_ctrl;
              r_owner    <= w_idx;
              r_busy     <= 1'b1;
              r_state    <= S_EXEC;
            end else begin
              // Illegal opcode completes without touching the ALU inputs.
              r_rsp_valid[w_idx] <= 1'b1;
              r_rsp_zero[w_idx]  <= 1'b0;
              r_rsp_err[w_idx]   <= 1'b1;
              if (w_idx) r_rsp_result1 <= '0;
              else       r_rsp_result0 <= '0;
            end
          end
        end
        S_EXEC: begin
          r_state              <= S_IDLE;
          r_busy               <= 1'b0;
          r_rsp_valid[r_owner] <= 1'b1;
          r_rsp_zero[r_owner]  <= (r_alu_ctrl == OP_SUB) && alu_zero;
          r_rsp_err[r_owner]   <= 1'b0;
          if (r_owner) r_rsp_result1 <= alu_result;
          else         r_rsp_result0 <= alu_result;
        end
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_err     = r_rsp_err;
  assign rsp_result0 = r_rsp_result0;
  assign rsp_result1 = r_rsp_result1;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_result0, rsp_result1;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  req_ctrl0, req_ctrl1, alu_ctrl;
  logic        alu_zero, busy;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    logic [1:0]  rv, rr;
    logic [31:0] a0, b0;
    logic [3:0]  c0;
    logic [31:0] a1, b1;
    logic [3:0]  c1;
    logic [1:0]  rdy;
    logic        bsy;
    logic [1:0]  rspv;
    logic [31:0] r0, r1;
    logic [1:0]  z, e;
    logic [31:0] aa, ab;
    logic [3:0]  ac;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [1:0] rv, logic [1:0] rr,
                              logic [31:0] a0, logic [31:0] b0, logic [3:0] c0,
                              logic [31:0] a1, logic [31:0] b1, logic [3:0] c1,
                              logic [1:0] rdy, logic bsy, logic [1:0] rspv,
                              logic [31:0] r0, logic [31:0] r1,
                              logic [1:0] z, logic [1:0] e,
                              logic [31:0] aa, logic [31:0] ab, logic [3:0] ac);
    vec_t v;
    v.rv = rv; v.rr = rr; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rdy = rdy; v.bsy = bsy; v.rspv = rspv;
    v.r0 = r0; v.r1 = r1; v.z = z; v.e = e; v.aa = aa; v.ab = ab; v.ac = ac;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.rv; rsp_ready = v.rr;
    req_a0 = v.a0; req_b0 = v.b0; req_ctrl0 = v.c0;
    req_a1 = v.a1; req_b1 = v.b1; req_ctrl1 = v.c1;
  endtask

  localparam logic [31:0] X = 32'h0;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] PA = 32'hF0F0_0000;
  localparam logic [31:0] PB = 32'hFF00_FF00;

  initial begin
    vec_t v;
    bit   seen;
    //        rv     rr     a0   b0  c0     a1 b1 c1     rdy   bsy rspv  r0            r1  z      e      aa   ab  ac
    tv.push_back(mk(2'b01,2'b00,5,7,4'h2, X,X,4'h0, 2'b01,1,2'b00, X,X, 2'b00,2'b00, 5,7,4'h2));
    tv.push_back(mk(2'b00,2'b00,5,7,4'h2, X,X,4'h0, 2'b00,0,2'b01, 12,X, 2'b00,2'b00, 5,7,4'h2));
    tv.push_back(mk(2'b00,2'b00,5,7,4'h2, X,X,4'h0, 2'b00,0,2'b01, 12,X, 2'b00,2'b00, 5,7,4'h2));
    tv.push_back(mk(2'b00,2'b01,5,7,4'h2, X,X,4'h0, 2'b00,0,2'b00, X,X, 2'b00,2'b00, 5,7,4'h2));
    tv.push_back(mk(2'b01,2'b11,PA,PB,4'h0, X,X,4'h0, 2'b01,1,2'b00, X,X, 2'b00,2'b00, PA,PB,4'h0));
    tv.push_back(mk(2'b00,2'b11,PA,PB,4'h0, X,X,4'h0, 2'b00,0,2'b01, 32'hF000_0000,X, 2'b00,2'b00, PA,PB,4'h0));
    tv.push_back(mk(2'b01,2'b11,PA,PB,4'h1, X,X,4'h0, 2'b00,0,2'b00, X,X, 2'b00,2'b00, PA,PB,4'h0));
    tv.push_back(mk(2'b01,2'b11,PA,PB,4'h1, X,X,4'h0, 2'b01,1,2'b00, X,X, 2'b00,2'b00, PA,PB,4'h1));
    tv.push_back(mk(2'b00,2'b11,PA,PB,4'h1, X,X,4'h0, 2'b00,0,2'b01, 32'hFFF0_FF00,X, 2'b00,2'b00, PA,PB,4'h1));
    tv.push_back(mk(2'b00,2'b11,PA,PB,4'h1, X,X,4'h0, 2'b00,0,2'b00, X,X, 2'b00,2'b00, PA,PB,4'h1));
    // both requesters SUB 9-9 back to back: grants alternate, one every two cycles
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b10,1,2'b00, X,X, 2'b00,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b00,0,2'b10, X,0, 2'b10,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b01,1,2'b00, X,X, 2'b00,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b00,0,2'b01, 0,X, 2'b01,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b10,1,2'b00, X,X, 2'b00,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b11,2'b11,9,9,4'h6, 9,9,4'h6, 2'b00,0,2'b10, X,0, 2'b10,2'b00, 9,9,4'h6));
    tv.push_back(mk(2'b00,2'b11,9,9,4'h6, 9,9,4'h6, 2'b00,0,2'b00, X,X, 2'b00,2'b00, 9,9,4'h6));
    // wrap-around ADD with slot 0 left pending; requester 1 still served
    tv.push_back(mk(2'b01,2'b00,MAX,1,4'h2, 3,4,4'h2, 2'b01,1,2'b00, X,X, 2'b00,2'b00, MAX,1,4'h2));
    tv.push_back(mk(2'b01,2'b00,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b01, 0,X, 2'b00,2'b00, MAX,1,4'h2));
    tv.push_back(mk(2'b11,2'b00,MAX,1,4'h2, 3,4,4'h2, 2'b10,1,2'b01, 0,X, 2'b00,2'b00, 3,4,4'h2));
    tv.push_back(mk(2'b11,2'b00,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b11, 0,7, 2'b00,2'b00, 3,4,4'h2));
    tv.push_back(mk(2'b01,2'b00,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b11, 0,7, 2'b00,2'b00, 3,4,4'h2));
    tv.push_back(mk(2'b01,2'b01,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b10, X,7, 2'b00,2'b00, 3,4,4'h2));
    tv.push_back(mk(2'b01,2'b10,MAX,1,4'h2, 3,4,4'h2, 2'b01,1,2'b00, X,X, 2'b00,2'b00, MAX,1,4'h2));
    tv.push_back(mk(2'b00,2'b11,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b01, 0,X, 2'b00,2'b00, MAX,1,4'h2));
    tv.push_back(mk(2'b00,2'b11,MAX,1,4'h2, 3,4,4'h2, 2'b00,0,2'b00, X,X, 2'b00,2'b00, MAX,1,4'h2));
    // illegal opcode on requester 1: immediate error response, ALU untouched
    tv.push_back(mk(2'b10,2'b00,X,X,4'h0, 3,4,4'h7, 2'b10,0,2'b10, X,0, 2'b00,2'b10, MAX,1,4'h2));
    tv.push_back(mk(2'b00,2'b10,X,X,4'h0, 3,4,4'h7, 2'b00,0,2'b00, X,X, 2'b00,2'b00, MAX,1,4'h2));

    rst_n = 1'b0;
    drive(mk(2'b01,2'b00,5,7,4'h2, X,X,4'h0, 0,0,0, X,X, 0,0, X,X,4'h0));
    #12;
    chk("reset_req_ready", {30'd0, req_ready}, 0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_rsp_result0", rsp_result0, 0);
    chk("reset_rsp_err", {30'd0, rsp_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      drive(v);
      #1;
      chk($sformatf("v%0d_req_ready", i), {30'd0, req_ready}, {30'd0, v.rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, v.bsy});
      chk($sformatf("v%0d_rsp_valid", i), {30'd0, rsp_valid}, {30'd0, v.rspv});
      chk($sformatf("v%0d_rsp_zero", i), {30'd0, rsp_zero & v.rspv}, {30'd0, v.z});
      chk($sformatf("v%0d_rsp_err", i), {30'd0, rsp_err & v.rspv}, {30'd0, v.e});
      if (v.rspv[0]) chk($sformatf("v%0d_rsp_result0", i), rsp_result0, v.r0);
      if (v.rspv[1]) chk($sformatf("v%0d_rsp_result1", i), rsp_result1, v.r1);
      chk($sformatf("v%0d_alu_a", i), alu_a, v.aa);
      chk($sformatf("v%0d_alu_b", i), alu_b, v.ab);
      chk($sformatf("v%0d_alu_ctrl", i), {28'd0, alu_ctrl}, {28'd0, v.ac});
    end

    // Reset dropped mid-EXEC: last grant went to 1, so the tie goes to 0 first.
    drive(mk(2'b11,2'b11,5,7,4'h2, 9,9,4'h6, 0,0,0, X,X, 0,0, X,X,4'h0));
    #1;
    chk("pre_rst_req_ready", {30'd0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_req_ready", {30'd0, req_ready}, 0);
    chk("mid_rst_rsp_valid", {30'd0, rsp_valid}, 0);
    @(posedge clk); #1;
    chk("rst_held_rsp_valid", {30'd0, rsp_valid}, 0);
    rst_n = 1'b1;
    rsp_ready = 2'b00;
    #1;
    chk("post_rst_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("post_rst_tie_grant", {30'd0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("post_rst_busy", {31'd0, busy}, 1);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(posedge clk); #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    chk("post_rst_rsp_seen", {31'd0, seen}, 1);
    chk("post_rst_rsp_valid_owner", {30'd0, rsp_valid}, 32'h1);
    chk("post_rst_rsp_result0", rsp_result0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
